// File: rtl/ff_pkg.sv
// Shared constants for the flip-flop bank: operating modes and the SR-mode
// resolution policy applied when S and R are both asserted.
package ff_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'd0,
    MODE_JK = 2'd1,
    MODE_D  = 2'd2,
    MODE_T  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    SR11_HOLD = 2'd0,
    SR11_SET  = 2'd1,
    SR11_RST  = 2'd2,
    SR11_TGL  = 2'd3
  } sr11_e;

endpackage

// File: rtl/sr_ff_bank_if.sv
// Control and status bundle of the flip-flop bank. The master drives the
// mode and per-bit inputs; the slave (the bank) returns state and status.
interface sr_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic [1:0]       mode;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] chg;
  logic             illegal;
  logic [CNT_W-1:0] chg_cnt;

  modport master (
    output en, clr, mode, s, r,
    input  q, q_bar, chg, illegal, chg_cnt
  );

  modport slave (
    input  en, clr, mode, s, r,
    output q, q_bar, chg, illegal, chg_cnt
  );
endinterface

// File: rtl/ff_next_bit.sv
// Combinational next-state function of one flip-flop bit for all four modes.
module ff_next_bit
  import ff_pkg::*;
(
  input  logic [1:0] i_mode,
  input  logic       i_s,
  input  logic       i_r,
  input  logic       i_q,
  input  logic [1:0] i_policy,
  output logic       o_qNext
);

  always_comb begin
    o_qNext = i_q;
    case (i_mode)
      MODE_SR: begin
        case ({i_s, i_r})
          2'b10:   o_qNext = 1'b1;
          2'b01:   o_qNext = 1'b0;
          2'b11: begin
            // Simultaneous set and reset resolved by the build-time policy
            case (i_policy)
              SR11_HOLD: o_qNext = i_q;
              SR11_SET:  o_qNext = 1'b1;
              SR11_RST:  o_qNext = 1'b0;
              SR11_TGL:  o_qNext = ~i_q;
              default:   o_qNext = i_q;
            endcase
          end
          default: o_qNext = i_q;
        endcase
      end
      MODE_JK: begin
        case ({i_s, i_r})
          2'b10:   o_qNext = 1'b1;
          2'b01:   o_qNext = 1'b0;
          2'b11:   o_qNext = ~i_q;
          default: o_qNext = i_q;
        endcase
      end
      MODE_D:  o_qNext = i_s;
      MODE_T:  o_qNext = i_s ^ i_q;
      default: o_qNext = i_q;
    endcase
  end

endmodule

// File: rtl/sr_ff_bank.sv
// WIDTH-bit flip-flop bank with run-time mode, clear/enable, change pulses,
// a sticky illegal-SR-input flag and a saturating change-event counter.
module sr_ff_bank
  import ff_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RST_VAL     = '0,
  parameter int               SR11_POLICY = 0,
  parameter int               CNT_W       = 8
) (
  input logic         clk,
  input logic         rst_n,
  sr_ff_bank_if.slave bus
);

  localparam logic [1:0]       POLICY_SEL = SR11_POLICY[1:0];
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_chg;
  logic             r_illegal;
  logic [CNT_W-1:0] r_chgCnt;
  logic [WIDTH-1:0] w_qNext;
  logic             w_srConflict;

  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    ff_next_bit uNext (
      .i_mode   (bus.mode),
      .i_s      (bus.s[i]),
      .i_r      (bus.r[i]),
      .i_q      (r_q[i]),
      .i_policy (POLICY_SEL),
      .o_qNext  (w_qNext[i])
    );
  end

  assign w_srConflict = (bus.mode == MODE_SR) && (|(bus.s & bus.r));

  // Clear outranks enable; a disabled edge still drops the change pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= RST_VAL;
      r_chg     <= '0;
      r_illegal <= 1'b0;
      r_chgCnt  <= '0;
    end else if (bus.clr) begin
      r_q       <= RST_VAL;
      r_chg     <= '0;
      r_illegal <= 1'b0;
      r_chgCnt  <= '0;
    end else if (bus.en) begin
      r_q   <= w_qNext;
      r_chg <= w_qNext ^ r_q;
      if ((w_qNext != r_q) && (r_chgCnt != CNT_MAX)) begin
        r_chgCnt <= r_chgCnt + CNT_W'(1);
      end
      if (w_srConflict) begin
        r_illegal <= 1'b1;
      end
    end else begin
      r_chg <= '0;
    end
  end

  assign bus.q       = r_q;
  assign bus.q_bar   = ~r_q;
  assign bus.chg     = r_chg;
  assign bus.illegal = r_illegal;
  assign bus.chg_cnt = r_chgCnt;

endmodule
